fft_peak_detect: RTL and testbench

//  Downstream of the FFT. Captures the N-bin complex burst that follows each rising edge of all_fft_done.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_mag_sq.sv | 84 ++++++++
 rtl/fft_peak_detect.sv | 161 ++++++++++++++++
 tb/tb_fft_peak_detect.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Package: fft_pkg
// Shared constants and types for the FFT peak detector.
//   FFT_N        bins per frame (power of 2)
//   FFT_W        signed width of each FFT output component
//   MAG_W        unsigned width of a squared magnitude (2*FFT_W+1)
//   cplx_t       one complex FFT sample
//   peak_state_t capture FSM states
package fft_pkg;

  localparam int unsigned FFT_N = 32;
  localparam int unsigned FFT_W = 16;
  localparam int unsigned MAG_W = 2 * FFT_W + 1;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    DRAIN
  } peak_state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Module: fft_mag_sq
// Pipelined squared magnitude |x|^2 = re^2 + im^2 with valid and bin index carried alongside.
//   S0 registers the sample, S1 registers both squares, and the sum is formed combinationally
//   from S1 so that the consumer can compare and register it in the same cycle.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low
//   in_valid   in   sample present this edge
//   in_re      in   W-bit signed real part
//   in_im      in   W-bit signed imaginary part
//   in_idx     in   bin index of the sample
//   out_valid  out  out_sum/out_idx hold a valid bin
//   out_idx    out  bin index belonging to out_sum
//   out_sum    out  MAG_W-bit unsigned squared magnitude
module fft_mag_sq
  import fft_pkg::*;
#(
  parameter int unsigned W     = FFT_W,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned SUM_W = 2 * W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  input  logic [IDX_W-1:0]    in_idx,
  output logic                out_valid,
  output logic [IDX_W-1:0]    out_idx,
  output logic [SUM_W-1:0]    out_sum
);

  localparam int unsigned PW = 2 * W;

  logic                s0_valid;
  logic signed [W-1:0] s0_re;
  logic signed [W-1:0] s0_im;
  logic [IDX_W-1:0]    s0_idx;

  logic                s1_valid;
  logic [PW-1:0]       s1_re_sq;
  logic [PW-1:0]       s1_im_sq;
  logic [IDX_W-1:0]    s1_idx;

  // Signed squares are never negative and peak at 2^(2W-2), so 2W unsigned bits hold them.
  logic signed [PW-1:0] re_sq;
  logic signed [PW-1:0] im_sq;

  assign re_sq = s0_re * s0_re;
  assign im_sq = s0_im * s0_im;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid <= 1'b0;
      s0_re    <= '0;
      s0_im    <= '0;
      s0_idx   <= '0;
    end else begin
      s0_valid <= in_valid;
      s0_re    <= in_re;
      s0_im    <= in_im;
      s0_idx   <= in_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_re_sq <= re_sq;
      s1_im_sq <= im_sq;
      s1_idx   <= s0_idx;
    end
  end

  assign out_valid = s1_valid;
  assign out_idx   = s1_idx;
  assign out_sum   = SUM_W'(s1_re_sq) + SUM_W'(s1_im_sq);

endmodule

// File: rtl/fft_peak_detect.sv
// Module: fft_peak_detect
// Captures the N-bin complex burst following each rising edge of in_done, computes the squared
// magnitude of every bin and offers the strongest bin (lowest index on ties) on a valid/ready port.
// Build option: define PEAK_SKIP_DC_EN to exclude bin 0 from the search (best seeded by bin 1).
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low
//   in_re       in   W-bit signed FFT real output
//   in_im       in   W-bit signed FFT imaginary output
//   in_done     in   FFT all-done level; its rising edge starts a capture
//   peak_idx    out  bin index of the maximum
//   peak_mag    out  squared magnitude of that bin
//   peak_valid  out  result available
//   peak_ready  in   consumer accepts the result
//   busy        out  capture or pipeline in flight
//   overrun     out  sticky: an unaccepted result was replaced
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int unsigned N     = FFT_N,
  parameter int unsigned W     = FFT_W,
  parameter int unsigned IDX_W = $clog2(N),
  parameter int unsigned MAG_W = 2 * W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  input  logic                in_done,
  output logic [IDX_W-1:0]    peak_idx,
  output logic [MAG_W-1:0]    peak_mag,
  output logic                peak_valid,
  input  logic                peak_ready,
  output logic                busy,
  output logic                overrun
);

  peak_state_t state_q, state_d;
  logic [IDX_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             done_q;
  logic             start;
  logic             capture;
  logic             load;

  logic             mq_valid;
  logic [IDX_W-1:0] mq_idx;
  logic [MAG_W-1:0] mq_sum;

  logic [IDX_W-1:0] best_idx_q;
  logic [MAG_W-1:0] best_mag_q;
  logic             best_upd;

  assign start   = in_done & ~done_q & (state_q == IDLE);
  assign capture = start | (state_q == CAPT);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q      <= 1'b0;
      state_q     <= IDLE;
      bin_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      done_q      <= in_done;
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // bin_cnt_q is the index of the bin sampled this edge; it wraps back to 0 after bin N-1.
  // The result loads on the third edge after bin N-1 is sampled, once bin N-1 has reached best.
  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    drain_cnt_d = drain_cnt_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CAPT;
          bin_cnt_d = bin_cnt_q + 1'b1;
        end
      end
      CAPT: begin
        bin_cnt_d = bin_cnt_q + 1'b1;
        if (bin_cnt_q == IDX_W'(N - 1)) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == 2'd2) begin
          load        = 1'b1;
          state_d     = IDLE;
          drain_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  fft_mag_sq #(
    .W     (W),
    .IDX_W (IDX_W),
    .SUM_W (MAG_W)
  ) u_mag_sq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (capture),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_idx    (bin_cnt_q),
    .out_valid (mq_valid),
    .out_idx   (mq_idx),
    .out_sum   (mq_sum)
  );

  // The first competing bin of a frame always seeds best; later bins must be strictly greater,
  // so the lowest index wins a tie.
`ifdef PEAK_SKIP_DC_EN
  assign best_upd = mq_valid && (mq_idx != '0) &&
                    ((mq_sum > best_mag_q) || (mq_idx == IDX_W'(1)));
`else
  assign best_upd = mq_valid && ((mq_sum > best_mag_q) || (mq_idx == '0));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_idx_q <= '0;
      best_mag_q <= '0;
    end else if (best_upd) begin
      best_idx_q <= mq_idx;
      best_mag_q <= mq_sum;
    end
  end

  // A load wins over a same-edge accept; replacing an unaccepted result flags overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_idx   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      peak_idx   <= best_idx_q;
      peak_mag   <= best_mag_q;
      peak_valid <= 1'b1;
      if (peak_valid && !peak_ready) begin
        overrun <= 1'b1;
      end
    end else if (peak_valid && peak_ready) begin
      peak_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Testbench for fft_peak_detect: directed frames with hand-computed peak index and magnitude.
module tb_fft_peak_detect;

  logic        clk;
  logic        reset;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        in_done;
  logic [4:0]  peak_idx;
  logic [32:0] peak_mag;
  logic        peak_valid;
  logic        peak_ready;
  logic        busy;
  logic        overrun;

  int checks;
  int errors;

  logic [15:0] fr_re [32];
  logic [15:0] fr_im [32];

  fft_peak_detect dut (
    .clk        (clk),
    .reset      (reset),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_done    (in_done),
    .peak_idx   (peak_idx),
    .peak_mag   (peak_mag),
    .peak_valid (peak_valid),
    .peak_ready (peak_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_frame();
    for (int k = 0; k < 32; k++) begin
      fr_re[k] = 16'h0000;
      fr_im[k] = 16'h0000;
    end
  endtask

  // Leaves time at #1 after the edge that samples bin 31.
  task automatic run_frame();
    @(posedge clk); #1;
    in_done = 1'b1;
    in_re   = fr_re[0];
    in_im   = fr_im[0];
    for (int k = 1; k < 32; k++) begin
      @(posedge clk); #1;
      in_re = fr_re[k];
      in_im = fr_im[k];
    end
    @(posedge clk); #1;
    in_done = 1'b0;
    in_re   = 16'h0000;
    in_im   = 16'h0000;
  endtask

  task automatic accept_one();
    peak_ready = 1'b1;
    @(posedge clk); #1;
    peak_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({peak_idx, peak_mag, peak_valid, busy, overrun} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs: got idx=%0d mag=%h valid=%b busy=%b ovr=%b, want all 0",
               peak_idx, peak_mag, peak_valid, busy, overrun);
    end
  endtask

  task automatic test_single_peak();
    clear_frame();
    fr_re[5] = 16'h0100;
    run_frame();
    checks++;
    if (busy !== 1'b1 || peak_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_after_bin31: busy=%b valid=%b, want busy=1 valid=0", busy, peak_valid);
    end
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #1;
      checks++;
      if (peak_valid !== 1'b0) begin
        errors++;
        $display("FAIL t1_early_valid: edge %0d after bin31 valid=%b, want 0", e, peak_valid);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_idx !== 5'd5 || peak_mag !== 33'h10000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_result: valid=%b idx=%0d mag=%h busy=%b, want 1 5 000010000 0",
               peak_valid, peak_idx, peak_mag, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_idx !== 5'd5) begin
      errors++;
      $display("FAIL t1_hold: valid=%b idx=%0d, want 1 5", peak_valid, peak_idx);
    end
    accept_one();
    checks++;
    if (peak_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_accept: valid=%b, want 0", peak_valid);
    end
  endtask

  task automatic test_tie();
    clear_frame();
    fr_re[3] = 16'h0010;
    fr_im[7] = 16'hFFF0;
    run_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_idx !== 5'd3 || peak_mag !== 33'h100) begin
      errors++;
      $display("FAIL t2_tie: valid=%b idx=%0d mag=%h, want 1 3 000000100",
               peak_valid, peak_idx, peak_mag);
    end
    accept_one();
  endtask

  task automatic test_dc();
    logic [4:0]  exp_idx;
    logic [32:0] exp_mag;
    clear_frame();
    fr_re[0] = 16'h7FFF;
    fr_re[9] = 16'h0001;
`ifdef PEAK_SKIP_DC_EN
    exp_idx = 5'd9;
    exp_mag = 33'h1;
`else
    exp_idx = 5'd0;
    exp_mag = 33'h3FFF0001;
`endif
    run_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_idx !== exp_idx || peak_mag !== exp_mag) begin
      errors++;
      $display("FAIL t3_dc: valid=%b idx=%0d mag=%h, want 1 %0d %h",
               peak_valid, peak_idx, peak_mag, exp_idx, exp_mag);
    end
    accept_one();
  endtask

  task automatic test_max_neg();
    clear_frame();
    fr_re[31] = 16'h8000;
    fr_im[31] = 16'h8000;
    run_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_idx !== 5'd31 || peak_mag !== 33'h080000000) begin
      errors++;
      $display("FAIL t4_maxneg: valid=%b idx=%0d mag=%h, want 1 31 080000000",
               peak_valid, peak_idx, peak_mag);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL t4_no_overrun: overrun=%b, want 0", overrun);
    end
    accept_one();
  endtask

  task automatic test_overrun();
    peak_ready = 1'b0;
    clear_frame();
    fr_re[2] = 16'h0020;
    run_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_idx !== 5'd2 || peak_mag !== 33'h400 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL t5_frame_a: valid=%b idx=%0d mag=%h ovr=%b, want 1 2 000000400 0",
               peak_valid, peak_idx, peak_mag, overrun);
    end
    clear_frame();
    fr_re[6] = 16'h0030;
    run_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_idx !== 5'd6 || peak_mag !== 33'h900 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL t5_frame_b: valid=%b idx=%0d mag=%h ovr=%b, want 1 6 000000900 1",
               peak_valid, peak_idx, peak_mag, overrun);
    end
    accept_one();
    checks++;
    if (peak_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL t5_accept: valid=%b ovr=%b, want 0 1", peak_valid, overrun);
    end
  endtask

  task automatic test_reset_mid_capture();
    clear_frame();
    fr_re[10] = 16'h0005;
    @(posedge clk); #1;
    in_done = 1'b1;
    in_re   = fr_re[0];
    in_im   = fr_im[0];
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      in_re = fr_re[k];
      in_im = fr_im[k];
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t6_busy_before: busy=%b, want 1", busy);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({peak_idx, peak_mag, peak_valid, busy, overrun} !== 41'd0) begin
      errors++;
      $display("FAIL t6_async_reset: idx=%0d mag=%h valid=%b busy=%b ovr=%b, want all 0",
               peak_idx, peak_mag, peak_valid, busy, overrun);
    end
    in_done = 1'b0;
    in_re   = 16'h0000;
    in_im   = 16'h0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t6_idle_after: valid=%b busy=%b, want 0 0", peak_valid, busy);
    end
    clear_frame();
    fr_re[12] = 16'h0003;
    fr_im[12] = 16'hFFFC;
    run_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_idx !== 5'd12 || peak_mag !== 33'h19 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL t6_recover: valid=%b idx=%0d mag=%h ovr=%b, want 1 12 000000019 0",
               peak_valid, peak_idx, peak_mag, overrun);
    end
    accept_one();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    in_re      = 16'h0000;
    in_im      = 16'h0000;
    in_done    = 1'b0;
    peak_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_single_peak();
    test_tie();
    test_dc();
    test_max_neg();
    test_overrun();
    test_reset_mid_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
